// File: rtl/sequenciador_entrada.sv
// ---------------------------------------------------------------------------
// sequenciador_entrada
//
// Keypad input sequencer feeding the calculator operator stage. Tracks the
// entry "digit A, operator, digit B, equals" and presents the operands, the
// operator, the enable and the FSM state to the next stage. Abandons a
// half-typed entry after TIMEOUT_CICLOS idle cycles in LE_OP/LE_B.
//
// Parameters:
//   TIMEOUT_CICLOS : idle cycles tolerated in LE_OP/LE_B (0 = no timeout)
//   LARG_TIMER     : idle counter width, 2**LARG_TIMER > TIMEOUT_CICLOS
//
// Ports:
//   clk          in   1  system clock, rising edge
//   reset        in   1  synchronous active-high reset
//   tecla        in   4  key code (0-9 digit, A mul, B sub, C add, D equals,
//                        E clear, F invalid)
//   tecla_valida in   1  high while a key is held
//   A            out  4  first operand
//   OP           out  4  operator code (only A/B/C are ever stored)
//   B            out  4  second operand
//   E            out  1  operator stage enable, high exactly in RESULTADO
//   Q            out  2  FSM state
//   erro         out  1  one-cycle pulse per rejected key
// ---------------------------------------------------------------------------
module sequenciador_entrada #(
    parameter int TIMEOUT_CICLOS = 50_000_000,
    parameter int LARG_TIMER     = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] tecla,
    input  logic       tecla_valida,
    output logic [3:0] A,
    output logic [3:0] OP,
    output logic [3:0] B,
    output logic       E,
    output logic [1:0] Q,
    output logic       erro
);

    typedef enum logic [1:0] {
        LE_A      = 2'b00,
        LE_OP     = 2'b01,
        LE_B      = 2'b10,
        RESULTADO = 2'b11
    } estado_t;

    localparam logic [3:0] TECLA_IGUAL = 4'hD;
    localparam logic [3:0] TECLA_LIMPA = 4'hE;
    localparam logic [LARG_TIMER-1:0] TIMER_FIM =
        LARG_TIMER'((TIMEOUT_CICLOS > 0) ? TIMEOUT_CICLOS - 1 : 0);

    estado_t               estado_q, estado_d;
    logic [3:0]            a_q, a_d;
    logic [3:0]            op_q, op_d;
    logic [3:0]            b_q, b_d;
    logic                  e_q, e_d;
    logic                  erro_q, erro_d;
    logic                  tem_b_q, tem_b_d;
    logic [LARG_TIMER-1:0] timer_q, timer_d;
    logic                  valida_ant_q, valida_ant_d;

    logic aceita;
    logic eh_digito;
    logic eh_operador;
    logic ocioso_conta;
    logic expira;

    // A key counts only on the rising edge of tecla_valida, so a held key
    // is taken exactly once.
    assign aceita       = tecla_valida & ~valida_ant_q;
    assign eh_digito    = (tecla <= 4'd9);
    assign eh_operador  = (tecla >= 4'hA) && (tecla <= 4'hC);
    assign ocioso_conta = (estado_q == LE_OP) || (estado_q == LE_B);
    assign expira       = (TIMEOUT_CICLOS != 0) && ocioso_conta && (timer_q == TIMER_FIM);

    always_comb begin
        // NOTE: every _d gets a default first so no path can infer a latch.
        estado_d     = estado_q;
        a_d          = a_q;
        op_d         = op_q;
        b_d          = b_q;
        tem_b_d      = tem_b_q;
        erro_d       = 1'b0;
        valida_ant_d = tecla_valida;

        if (aceita) begin
            // An accepted key takes priority over a timeout in the same cycle.
            if (tecla == TECLA_LIMPA) begin
                estado_d = LE_A;
                a_d      = '0;
                op_d     = '0;
                b_d      = '0;
                tem_b_d  = 1'b0;
            end else begin
                unique case (estado_q)
                    LE_A: begin
                        if (eh_digito) begin
                            a_d      = tecla;
                            estado_d = LE_OP;
                        end else begin
                            erro_d = 1'b1;
                        end
                    end
                    LE_OP: begin
                        if (eh_digito) begin
                            a_d = tecla;
                        end else if (eh_operador) begin
                            op_d     = tecla;
                            tem_b_d  = 1'b0;
                            estado_d = LE_B;
                        end else begin
                            erro_d = 1'b1;
                        end
                    end
                    LE_B: begin
                        if (eh_digito) begin
                            b_d     = tecla;
                            tem_b_d = 1'b1;
                        end else if (eh_operador) begin
                            op_d = tecla;
                        end else if (tecla == TECLA_IGUAL && tem_b_q) begin
                            estado_d = RESULTADO;
                        end else begin
                            erro_d = 1'b1;
                        end
                    end
                    RESULTADO: begin
                        // A digit here starts a fresh calculation.
                        if (eh_digito) begin
                            a_d      = tecla;
                            b_d      = '0;
                            op_d     = '0;
                            tem_b_d  = 1'b0;
                            estado_d = LE_OP;
                        end else begin
                            erro_d = 1'b1;
                        end
                    end
                    default: estado_d = LE_A;
                endcase
            end
        end else if (expira) begin
            estado_d = LE_A;
            a_d      = '0;
            op_d     = '0;
            b_d      = '0;
            tem_b_d  = 1'b0;
        end

        e_d = (estado_d == RESULTADO);

        // Idle counter only runs while waiting mid-entry with nothing happening.
        if (aceita || (estado_d != estado_q) || !ocioso_conta) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            estado_q     <= LE_A;
            a_q          <= '0;
            op_q         <= '0;
            b_q          <= '0;
            e_q          <= 1'b0;
            erro_q       <= 1'b0;
            tem_b_q      <= 1'b0;
            timer_q      <= '0;
            valida_ant_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            a_q          <= a_d;
            op_q         <= op_d;
            b_q          <= b_d;
            e_q          <= e_d;
            erro_q       <= erro_d;
            tem_b_q      <= tem_b_d;
            timer_q      <= timer_d;
            valida_ant_q <= valida_ant_d;
        end
    end

    assign A    = a_q;
    assign OP   = op_q;
    assign B    = b_q;
    assign E    = e_q;
    assign Q    = estado_q;
    assign erro = erro_q;

endmodule

// File: tb/tb_sequenciador_entrada.sv
// ---------------------------------------------------------------------------
// tb_sequenciador_entrada
//
// Drives directed scenarios and randomized key traffic into
// sequenciador_entrada (TIMEOUT_CICLOS = 16). Each driven cycle pushes the
// reference model's expected outputs into a queue; a monitor pops one entry
// per clock and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_sequenciador_entrada;

    localparam int T_OUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] tecla = '0;
    logic       tecla_valida = 1'b0;
    logic [3:0] A, OP, B;
    logic       E, erro;
    logic [1:0] Q;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] op;
        logic [3:0] b;
        logic       e;
        logic [1:0] q;
        logic       erro;
    } saida_t;

    saida_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase of the entry and the values typed so far.
    int m_fase    = 0;   // 0 waiting A, 1 waiting operator, 2 waiting B, 3 result
    int m_a       = 0;
    int m_op      = 0;
    int m_b       = 0;
    int m_ocioso  = 0;
    bit m_temb    = 0;
    bit m_ant     = 0;
    bit m_erro    = 0;

    sequenciador_entrada #(.TIMEOUT_CICLOS(T_OUT), .LARG_TIMER(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .tecla        (tecla),
        .tecla_valida (tecla_valida),
        .A            (A),
        .OP           (OP),
        .B            (B),
        .E            (E),
        .Q            (Q),
        .erro         (erro)
    );

    always #5 clk = ~clk;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_checks++;
        if (atual === esperado) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nome, atual, esperado);
    endtask

    function automatic void limpa_modelo();
        m_fase = 0; m_a = 0; m_op = 0; m_b = 0; m_temb = 0; m_ocioso = 0;
    endfunction

    function automatic void modelo(input bit rst, input int k, input bit v);
        bit borda;
        if (rst) begin
            limpa_modelo();
            m_ant  = 0;
            m_erro = 0;
            return;
        end
        borda  = v && !m_ant;
        m_ant  = v;
        m_erro = 0;
        if (borda) begin
            m_ocioso = 0;
            if (k == 14) begin
                limpa_modelo();
            end else if (k <= 9) begin
                if (m_fase == 0)      begin m_a = k; m_fase = 1; end
                else if (m_fase == 1) m_a = k;
                else if (m_fase == 2) begin m_b = k; m_temb = 1; end
                else begin m_a = k; m_b = 0; m_op = 0; m_temb = 0; m_fase = 1; end
            end else if (k >= 10 && k <= 12) begin
                if (m_fase == 1)      begin m_op = k; m_temb = 0; m_fase = 2; end
                else if (m_fase == 2) m_op = k;
                else m_erro = 1;
            end else if (k == 13 && m_fase == 2 && m_temb) begin
                m_fase = 3;
            end else begin
                m_erro = 1;
            end
        end else if (m_fase == 1 || m_fase == 2) begin
            if (m_ocioso == T_OUT - 1) limpa_modelo();
            else m_ocioso++;
        end else begin
            m_ocioso = 0;
        end
    endfunction

    // One clock of stimulus; expected outputs after the following edge are queued.
    task automatic drive(input bit rst, input logic [3:0] k, input bit v);
        saida_t s;
        @(negedge clk);
        reset        = rst;
        tecla        = k;
        tecla_valida = v;
        modelo(rst, int'(k), v);
        s.a    = 4'(m_a);
        s.op   = 4'(m_op);
        s.b    = 4'(m_b);
        s.e    = (m_fase == 3);
        s.q    = 2'(m_fase);
        s.erro = m_erro;
        exp_q.push_back(s);
    endtask

    task automatic press(input logic [3:0] k);
        drive(0, k, 1);
        repeat (3) drive(0, k, 0);
    endtask

    task automatic do_reset();
        drive(1, 4'h0, 0);
        drive(0, 4'h0, 0);
    endtask

    task automatic monitor();
        saida_t esp;
        saida_t atual;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                esp   = exp_q.pop_front();
                atual = {A, OP, B, E, Q, erro};
                check("saida", 32'(atual), 32'(esp));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r;
        logic [3:0] k;
        fork
            monitor();
        join_none

        // Reset state
        do_reset();
        check("reset_saidas", 32'({A, OP, B, E, Q, erro}), 32'h0);

        // Full sequence 3 * 4 =
        press(4'h3);  check("seq_q1", 32'(Q), 32'd1);
        press(4'hA);  check("seq_q2", 32'(Q), 32'd2);
        press(4'h4);  check("seq_q2b", 32'(Q), 32'd2);
        press(4'hD);
        check("seq_q3", 32'(Q), 32'd3);
        check("seq_a", 32'(A), 32'd3);
        check("seq_op", 32'(OP), 32'hA);
        check("seq_b", 32'(B), 32'd4);
        check("seq_e", 32'(E), 32'd1);

        // Held key accepted once
        do_reset();
        repeat (10) drive(0, 4'h5, 1);
        drive(0, 4'h5, 0);
        press(4'hB);
        check("hold_q", 32'(Q), 32'd2);
        check("hold_op", 32'(OP), 32'hB);
        check("hold_a", 32'(A), 32'd5);

        // Equals rejected in LE_OP and in LE_B without B
        do_reset();
        press(4'h2);
        drive(0, 4'hD, 1);
        drive(0, 4'hD, 0);
        check("erro_op_pulso", 32'(erro), 32'd1);
        check("erro_op_q", 32'(Q), 32'd1);
        check("erro_op_a", 32'(A), 32'd2);
        drive(0, 4'hD, 0);
        check("erro_op_fim", 32'(erro), 32'd0);
        press(4'hA);
        drive(0, 4'hD, 1);
        drive(0, 4'hD, 0);
        check("erro_b_pulso", 32'(erro), 32'd1);
        check("erro_b_q", 32'(Q), 32'd2);
        drive(0, 4'hD, 0);
        check("erro_b_fim", 32'(erro), 32'd0);

        // Timeout after 16 idle cycles in LE_OP
        do_reset();
        drive(0, 4'h7, 1);
        repeat (16) drive(0, 4'h7, 0);
        check("timeout_ainda_01", 32'(Q), 32'd1);
        drive(0, 4'h0, 0);
        check("timeout_q", 32'(Q), 32'd0);
        check("timeout_a", 32'(A), 32'd0);

        // Key on the expiry cycle wins
        do_reset();
        drive(0, 4'h7, 1);
        repeat (15) drive(0, 4'h7, 0);
        drive(0, 4'h8, 1);
        drive(0, 4'h8, 0);
        check("colisao_a", 32'(A), 32'd8);
        check("colisao_q", 32'(Q), 32'd1);

        // New calculation from RESULTADO
        do_reset();
        press(4'h9); press(4'hC); press(4'h2); press(4'hD);
        check("res_e", 32'(E), 32'd1);
        drive(0, 4'h1, 1);
        drive(0, 4'h1, 0);
        check("novo_calc", 32'({A, OP, B, E, Q}), 32'({4'h1, 4'h0, 4'h0, 1'b0, 2'b01}));

        // Reset beats a digit edge in the same cycle
        do_reset();
        press(4'h6); press(4'hB); press(4'h8);
        check("pre_reset_q", 32'(Q), 32'd2);
        drive(1, 4'h3, 1);
        drive(0, 4'h3, 0);
        check("reset_meio", 32'({A, OP, B, E, Q, erro}), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                drive(1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end else if (r < 6) begin
                repeat ($urandom_range(10, 20)) drive(0, 4'h0, 0);
            end else begin
                r = int'($urandom_range(0, 99));
                if (r < 50)      k = 4'($urandom_range(0, 9));
                else if (r < 75) k = 4'($urandom_range(10, 12));
                else if (r < 88) k = 4'hD;
                else if (r < 95) k = 4'hE;
                else             k = 4'hF;
                drive(0, k, 1'($urandom_range(0, 1)));
            end
        end

        drive(0, 4'h0, 0);
        @(posedge clk);
        #3;
        check("fila_vazia", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sequenciador_entrada.md
Name: sequenciador_entrada

Overview:
- Keypad input sequencer directly upstream of the calculator operator stage.
- Takes raw 4-bit key codes from the keypad decoder and tracks the entry sequence "digit A, operator, digit B, equals" with a 4-state FSM.
- Drives the operator stage's A, OP, B, E and Q inputs.
- Q=01 is the state in which the operator stage forces its result to zero.

Parameters:
- TIMEOUT_CICLOS, default 50_000_000: idle cycles allowed in states LE_OP/LE_B before the entry is abandoned. 0 disables the timeout.
- LARG_TIMER, default 26: width of the idle counter. Must satisfy 2^LARG_TIMER > TIMEOUT_CICLOS.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- tecla, input, 4: key code. 0000-1001 digit 0-9; 1010 multiply; 1011 subtract; 1100 add; 1101 equals; 1110 clear; 1111 invalid.
- tecla_valida, input, 1: level, high while a key is held.
- A, output, 4: first operand, registered.
- OP, output, 4: operator code, registered; only 1010/1011/1100 are ever stored.
- B, output, 4: second operand, registered.
- E, output, 1: enable for the operator stage, registered.
- Q, output, 2: FSM state, encoded as below.
- erro, output, 1: one-cycle pulse on a rejected key.

Behaviour:
- Reset: one clk edge with reset=1 gives A=0, B=0, OP=0, E=0, Q=00, erro=0, timer=0, tem_b=0, and the edge-detect register set to 0. Reset overrides every other event, including a key accepted in the same cycle.
- Key acceptance: a key is accepted only on a rising edge of tecla_valida, i.e. tecla_valida=1 in the current cycle and the registered previous sample =0. tecla is sampled in that same cycle. A held key is accepted exactly once.
- Timing: all effects of an accepted key appear on the outputs the cycle after the accepting edge (latency 1).
- Digit/operator checks: digit means tecla <= 1001; operator means tecla in 1010..1100.
- States (Q):
  - 00 LE_A
  - 01 LE_OP
  - 10 LE_B
  - 11 RESULTADO
- LE_A (00):
  - digit: A=digit, go to 01.
  - clear: A=B=OP=0, stay.
  - operator, equals or 1111: erro pulse, stay.
- LE_OP (01):
  - digit: A overwritten, stay.
  - operator: OP=tecla, go to 10, tem_b=0.
  - clear: A=B=OP=0, go to 00.
  - equals or 1111: erro pulse, stay.
- LE_B (10):
  - digit: B=digit, tem_b=1, stay.
  - operator: OP overwritten, stay.
  - equals with tem_b=1: go to 11, E=1.
  - equals with tem_b=0: erro pulse, stay.
  - clear: all registers zero, go to 00.
  - 1111: erro pulse, stay.
- RESULTADO (11):
  - E held at 1; A/B/OP held stable.
  - digit: A=digit, B=0, OP=0, E=0, tem_b=0, go to 01 (new calculation).
  - clear: all zero, go to 00.
  - operator, equals or 1111: erro pulse, stay.
- E is 1 exactly while Q=11 and 0 in every other state.
- Idle timer:
  - Counts only in states 01 and 10.
  - Zeroed on any accepted key, on any state change, and in states 00/11.
  - When the timer reaches TIMEOUT_CICLOS-1 with no key accepted that cycle: next cycle A=B=OP=0, Q=00, timer=0, no erro.
  - A key accepted in the same cycle as expiry wins; the timeout is discarded.
- erro: high for exactly one cycle per rejected key, otherwise 0. It does not change state or registers.
- Reset mid-operation: any state returns to 00 with all outputs zero on the next edge.

Test Plan:
- Key sequence 0011, 1010, 0100, 1101 (each a 1-cycle tecla_valida pulse, gaps of 3 cycles) -> Q steps 00→01→10→11; final A=3, OP=1010, B=4, E=1, erro never high.
- tecla=0101 with tecla_valida held high for 10 cycles in LE_A, then 1011 pulsed -> A=5 accepted once; Q=10, OP=1011, no spurious re-acceptance.
- In LE_OP, press 1101 -> erro=1 for exactly one cycle, Q stays 01, A unchanged. In LE_B with tem_b=0, press 1101 -> same single erro pulse, Q stays 10.
- TIMEOUT_CICLOS=16: accept digit 7, then idle -> Q=01 for 16 cycles, then Q=00, A=0.
- TIMEOUT_CICLOS=16, key collision: press a key on the expiry cycle -> key processed, no timeout.
- In RESULTADO (A=9, OP=1100, B=2, E=1), press 0001 -> next cycle A=1, B=0, OP=0, E=0, Q=01.
- Assert reset for 1 cycle while in LE_B with A=6, OP=1011, B=8, in the same cycle as a digit edge -> next cycle all outputs 0, Q=00. The digit is ignored.
